button_bank: RTL and testbench

//   Multi-channel push-button conditioner for the 7-segment front panel. Each channel has a
//   2-FF synchroniser, counter debounce, press/release one-shots and long-press detection.

---
 rtl/button_bank.sv | 172 +++++++++++++++++
 tb/tb_button_bank.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// Multi-channel push-button conditioner: synchroniser, debounce, press/release/long one-shots.
// Define BUTTON_AUTOREPEAT_EN to build the auto-repeat counter; otherwise repeat_pulse is tied 0.
module button_bank #(
  parameter int N_BTN         = 4,
  parameter int DB_CYCLES     = 50000,
  parameter int LONG_CYCLES   = 500000,
  parameter int REPEAT_CYCLES = 100000,
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic             sync1_r, sync2_r;
    logic [CNT_W-1:0] db_cnt_r, db_cnt_s;
    logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
    logic             level_r, level_s;
    logic             rise_s, fall_s, long_s;
    logic             press_r, release_r, long_r;
    state_t           state_r, state_s;

    // Two-flop synchroniser for the raw pin
    always_ff @(posedge clk) begin
      if (!reset) begin
        sync1_r <= 1'b0;
        sync2_r <= 1'b0;
      end else begin
        sync1_r <= btn_in[i];
        sync2_r <= sync1_r;
      end
    end

    // Debounce: accept a new level only after DB_CYCLES consecutive disagreeing samples
    always_comb begin
      db_cnt_s = CNT_ZERO;
      level_s  = level_r;
      rise_s   = 1'b0;
      fall_s   = 1'b0;
      if (sync2_r != level_r) begin
        if (db_cnt_r == DB_LAST) begin
          level_s = sync2_r;
          rise_s  = sync2_r;
          fall_s  = ~sync2_r;
        end else begin
          db_cnt_s = db_cnt_r + CNT_ONE;
        end
      end else begin
        db_cnt_s = CNT_ZERO;
      end
    end

    // Hold FSM next state; a release always wins over reaching the long threshold
    always_comb begin
      state_s    = state_r;
      hold_cnt_s = hold_cnt_r;
      long_s     = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            state_s    = ST_HELD;
            hold_cnt_s = CNT_ZERO;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (fall_s) begin
            state_s = ST_IDLE;
          end else if (hold_cnt_r == LONG_LAST) begin
            state_s = ST_LONG;
            long_s  = 1'b1;
          end else begin
            hold_cnt_s = hold_cnt_r + CNT_ONE;
          end
        end
        ST_LONG: begin
          if (fall_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_LONG;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          hold_cnt_s = CNT_ZERO;
        end
      endcase
    end

    // Channel state and registered one-shot outputs
    always_ff @(posedge clk) begin
      if (!reset) begin
        db_cnt_r   <= CNT_ZERO;
        hold_cnt_r <= CNT_ZERO;
        level_r    <= 1'b0;
        press_r    <= 1'b0;
        release_r  <= 1'b0;
        long_r     <= 1'b0;
        state_r    <= ST_IDLE;
      end else begin
        db_cnt_r   <= db_cnt_s;
        hold_cnt_r <= hold_cnt_s;
        level_r    <= level_s;
        press_r    <= rise_s;
        release_r  <= fall_s;
        long_r     <= long_s;
        state_r    <= state_s;
      end
    end

    assign btn_level[i]     = level_r;
    assign press_pulse[i]   = press_r;
    assign release_pulse[i] = release_r;
    assign long_pulse[i]    = long_r;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_cnt_r, rep_cnt_s;
    logic             rep_s, rep_r;

    // Repeat period counter; it idles at zero so the first period starts at long_pulse
    always_comb begin
      rep_cnt_s = CNT_ZERO;
      rep_s     = 1'b0;
      if ((state_r == ST_LONG) && !fall_s) begin
        if (rep_cnt_r == REP_LAST) begin
          rep_s     = 1'b1;
          rep_cnt_s = CNT_ZERO;
        end else begin
          rep_cnt_s = rep_cnt_r + CNT_ONE;
        end
      end else begin
        rep_cnt_s = CNT_ZERO;
      end
    end

    // Repeat counter and registered repeat pulse
    always_ff @(posedge clk) begin
      if (!reset) begin
        rep_cnt_r <= CNT_ZERO;
        rep_r     <= 1'b0;
      end else begin
        rep_cnt_r <= rep_cnt_s;
        rep_r     <= rep_s;
      end
    end

    assign repeat_pulse[i] = rep_r;
`else
    assign repeat_pulse[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_bank.sv
// Self-checking bench for button_bank: directed scenarios plus random bouncing inputs,
// checked every cycle against a sample-window / hold-age reference model.
module tb_button_bank;
  localparam int N    = 2;
  localparam int DB   = 4;
  localparam int LG   = 20;
  localparam int RP   = 5;
  localparam int CW   = 8;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn_in;
  logic [1:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

  button_bank #(.N_BTN(N), .DB_CYCLES(DB), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model history: input sampled at each edge and whether reset was active there
  logic [1:0] x_h [MAXC];
  logic       rst_h [MAXC];
  logic [1:0] m_lvl;
  int         press_at [2];
  logic [1:0] e_lvl, e_press, e_rel, e_long, e_rep;

  // observed event log
  int   n_press [2], n_rel [2], n_long [2], n_rep [2];
  int   t_press [2], t_rel [2], t_long [2], t_rep [2];
  logic saw_both;

  function automatic logic y_at(int e, int ch);
    if (e < 2) return 1'b0;
    if (rst_h[e-1] || rst_h[e-2]) return 1'b0;
    return x_h[e-2][ch];
  endfunction

  task automatic model_edge();
    e_press = 2'b00; e_rel = 2'b00; e_long = 2'b00; e_rep = 2'b00;
    for (int ch = 0; ch < N; ch++) begin
      if (rst_h[cyc]) begin
        m_lvl[ch]    = 1'b0;
        press_at[ch] = -1;
      end else begin
        logic chg;
        int   age;
        chg = 1'b1;
        for (int j = 0; j < DB; j++) begin
          if ((cyc - j) < 1) chg = 1'b0;
          else if (rst_h[cyc-j] || (y_at(cyc - j, ch) == m_lvl[ch])) chg = 1'b0;
        end
        if (chg) begin
          if (m_lvl[ch]) e_rel[ch] = 1'b1;
          else begin
            e_press[ch]  = 1'b1;
            press_at[ch] = cyc;
          end
          m_lvl[ch] = ~m_lvl[ch];
        end
        age = cyc - press_at[ch];
        if (m_lvl[ch] && press_at[ch] >= 0 && age == LG) e_long[ch] = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
        if (m_lvl[ch] && press_at[ch] >= 0 && age > LG && ((age - LG) % RP) == 0) e_rep[ch] = 1'b1;
`endif
      end
    end
    e_lvl = m_lvl;
  endtask

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_ev();
    for (int ch = 0; ch < N; ch++) begin
      n_press[ch] = 0; n_rel[ch] = 0; n_long[ch] = 0; n_rep[ch] = 0;
      t_press[ch] = -1; t_rel[ch] = -1; t_long[ch] = -1; t_rep[ch] = -1;
    end
    saw_both = 1'b0;
  endtask

  // one clock: drive, edge, update model, sample away from the edge, compare
  task automatic tick(input logic [1:0] b, input logic rn);
    btn_in = b;
    reset  = rn;
    @(posedge clk);
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL history_overflow cyc=%0d", cyc);
      $fatal(1, "history overflow");
    end
    x_h[cyc]   = b;
    rst_h[cyc] = ~rn;
    model_edge();
    #1;
    chk("level",   btn_level,     e_lvl);
    chk("press",   press_pulse,   e_press);
    chk("release", release_pulse, e_rel);
    chk("long",    long_pulse,    e_long);
    chk("repeat",  repeat_pulse,  e_rep);
    for (int ch = 0; ch < N; ch++) begin
      if (press_pulse[ch])   begin n_press[ch]++; t_press[ch] = cyc; end
      if (release_pulse[ch]) begin n_rel[ch]++;   t_rel[ch]   = cyc; end
      if (long_pulse[ch])    begin n_long[ch]++;  t_long[ch]  = cyc; end
      if (repeat_pulse[ch])  begin n_rep[ch]++;   t_rep[ch]   = cyc; end
    end
    if (press_pulse == 2'b11) saw_both = 1'b1;
  endtask

  initial begin
    int t0, tf, p, tr;
    int run [2];
    logic [1:0] cur;

    btn_in     = 2'b00;
    reset      = 1'b0;
    x_h[0]     = 2'b00;
    rst_h[0]   = 1'b1;
    m_lvl      = 2'b00;
    press_at[0] = -1;
    press_at[1] = -1;
    clear_ev();

    repeat (4) tick(2'b00, 1'b0);
    while (cyc < 10) tick(2'b00, 1'b1);

    // single press on channel 0, pin rises after edge 10
    clear_ev();
    t0 = cyc;
    repeat (6) tick(2'b01, 1'b1);
    chk_int("s1_press_time", t_press[0], t0 + 6);
    chk_int("s1_press_count", n_press[0], 1);
    chk_int("s1_ch1_quiet", n_press[1], 0);

    // short hold then release: no long pulse
    repeat (8) tick(2'b01, 1'b1);
    tf = cyc;
    repeat (10) tick(2'b00, 1'b1);
    chk_int("s3_release_time", t_rel[0], tf + 6);
    chk_int("s3_no_long", n_long[0], 0);

    // bounce shorter than the debounce window, then settle high
    repeat (4) tick(2'b00, 1'b1);
    clear_ev();
    for (int k = 0; k < 12; k++) tick((((k / 2) % 2) == 0) ? 2'b01 : 2'b00, 1'b1);
    tf = cyc;
    repeat (8) tick(2'b01, 1'b1);
    chk_int("s2_press_count", n_press[0], 1);
    chk_int("s2_release_count", n_rel[0], 0);
    chk_int("s2_press_time", t_press[0], tf + 6);
    repeat (10) tick(2'b00, 1'b1);

    // long hold: long pulse and auto-repeats
    clear_ev();
    t0 = cyc;
    p  = t0 + 6;
    while (cyc < p + 36) tick(2'b01, 1'b1);
    repeat (12) tick(2'b00, 1'b1);
    chk_int("s4_press_time", t_press[0], p);
    chk_int("s4_long_time", t_long[0], p + LG);
    chk_int("s4_long_count", n_long[0], 1);
    chk_int("s4_release_time", t_rel[0], p + 42);
`ifdef BUTTON_AUTOREPEAT_EN
    chk_int("s4_repeat_count", n_rep[0], 4);
    chk_int("s4_last_repeat", t_rep[0], p + 40);
`else
    chk_int("s4_repeat_count", n_rep[0], 0);
`endif

    // both channels at once
    clear_ev();
    t0 = cyc;
    repeat (8) tick(2'b11, 1'b1);
    chk_int("s5_both_same_cycle", int'(saw_both), 1);
    chk_int("s5_ch1_press_time", t_press[1], t0 + 6);
    p = t0 + 6;
    while (cyc < p + 10) tick(2'b11, 1'b1);

    // reset mid-hold, button still held afterwards
    clear_ev();
    repeat (3) tick(2'b11, 1'b0);
    tr = cyc;
    repeat (10) tick(2'b11, 1'b1);
    chk_int("s6_repress_time", t_press[0], tr + 6);
    chk_int("s6_no_release", n_rel[0] + n_rel[1], 0);
    repeat (12) tick(2'b00, 1'b1);

    // random bouncing presses of mixed lengths with rare resets
    cur    = 2'b00;
    run[0] = 1;
    run[1] = 1;
    for (int it = 0; it < 1500; it++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (run[ch] == 0) begin
          cur[ch] = ~cur[ch];
          run[ch] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6))
                                                : int'($urandom_range(1, 45));
        end
        run[ch]--;
      end
      tick(cur, ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
